// File: rtl/envelope_pkg.sv
// Shared ADSR envelope definitions: state encoding plus default step and sustain constants.
// Pure declarations; no latency or flow control involved.
package envelope_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } adsr_state_e;

  localparam int unsigned DEF_N            = 8;
  localparam int unsigned DEF_ATTACK_STEP  = 16;
  localparam int unsigned DEF_DECAY_STEP   = 4;
  localparam int unsigned DEF_SUSTAIN_LVL  = 128;
  localparam int unsigned DEF_RELEASE_STEP = 2;

endpackage

// File: rtl/envelope_adsr.sv
// ADSR envelope generator with output scaler; level steps on tick, sample_out lags level by 1 clk.
// No backpressure: note pulses are always accepted and take priority over a coincident tick.
module envelope_adsr
  import envelope_pkg::*;
#(
  parameter int unsigned N            = DEF_N,
  parameter int unsigned ATTACK_STEP  = DEF_ATTACK_STEP,
  parameter int unsigned DECAY_STEP   = DEF_DECAY_STEP,
  parameter int unsigned SUSTAIN_LVL  = DEF_SUSTAIN_LVL,
  parameter int unsigned RELEASE_STEP = DEF_RELEASE_STEP
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         note_on,
  input  logic         note_off,
  input  logic [N-1:0] sample_in,
  output logic [N-1:0] sample_out,
  output logic [N-1:0] level,
  output logic         busy
);

  localparam logic [N:0]   LVL_MAX_X = {1'b0, {N{1'b1}}};
  localparam logic [N:0]   ATK_X     = (N+1)'(ATTACK_STEP);
  localparam logic [N:0]   DEC_X     = (N+1)'(DECAY_STEP);
  localparam logic [N:0]   REL_X     = (N+1)'(RELEASE_STEP);
  localparam logic [N-1:0] SUS_LVL   = N'(SUSTAIN_LVL);

  adsr_state_e  state_q, state_d;
  logic [N-1:0] level_q, level_d;
  logic [N-1:0] sample_q, sample_d;
  logic         busy_q, busy_d;
  logic [N:0]   up_x, dn_x;

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    up_x    = '0;
    dn_x    = '0;

    // A note pulse swallows any coincident tick so retriggers never click.
    if (note_on) begin
      state_d = ST_ATTACK;
    end else if (note_off) begin
      if (state_q inside {ST_ATTACK, ST_DECAY, ST_SUSTAIN}) begin
        state_d = ST_RELEASE;
      end
    end else if (tick) begin
      case (state_q)
        ST_IDLE: begin
          level_d = '0;
        end
        ST_ATTACK: begin
          up_x = {1'b0, level_q} + ATK_X;
          if (up_x >= LVL_MAX_X) begin
            level_d = LVL_MAX_X[N-1:0];
            state_d = ST_DECAY;
          end else begin
            level_d = up_x[N-1:0];
          end
        end
        ST_DECAY: begin
          dn_x = {1'b0, level_q} - DEC_X;
          // Bit N set means the subtraction borrowed below zero.
          if (dn_x[N] || (dn_x[N-1:0] <= SUS_LVL)) begin
            level_d = SUS_LVL;
            state_d = ST_SUSTAIN;
          end else begin
            level_d = dn_x[N-1:0];
          end
        end
        ST_SUSTAIN: begin
          level_d = SUS_LVL;
        end
        ST_RELEASE: begin
          dn_x = {1'b0, level_q} - REL_X;
          if (dn_x[N] || (dn_x[N-1:0] == '0)) begin
            level_d = '0;
            state_d = ST_IDLE;
          end else begin
            level_d = dn_x[N-1:0];
          end
        end
        default: begin
          state_d = ST_IDLE;
          level_d = '0;
        end
      endcase
    end

    busy_d   = (state_d != ST_IDLE);
    sample_d = N'(({{N{1'b0}}, sample_in} * {{N{1'b0}}, level_q}) >> N);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      level_q  <= '0;
      sample_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
    end
  end

  assign level      = level_q;
  assign sample_out = sample_q;
  assign busy       = busy_q;

endmodule

// File: doc/envelope_adsr.md
ENVELOPE_ADSR -- requirements
Module: envelope_adsr

Interface
REQ-001 Parameter N, default 8: sample and envelope-level bitwidth.
REQ-002 Parameter ATTACK_STEP, default 16: level increment per tick in ATTACK.
REQ-003 Parameter DECAY_STEP, default 4: level decrement per tick in DECAY.
REQ-004 Parameter SUSTAIN_LVL, default 128: level held in SUSTAIN.
REQ-005 Parameter RELEASE_STEP, default 2: level decrement per tick in RELEASE.
REQ-006 Port clk, input, 1: single system clock; all state on its rising edge.
REQ-007 Port reset, input, 1: asynchronous, active-low reset.
REQ-008 Port tick, input, 1: sample-rate enable (fs = 8 kHz), one clk wide.
REQ-009 Port note_on, input, 1: one-clk pulse that starts or retriggers a tone.
REQ-010 Port note_off, input, 1: one-clk pulse that ends a tone.
REQ-011 Port sample_in, input, N: unsigned sine sample from the sine generator.
REQ-012 Port sample_out, output, N: envelope-scaled sample; drives the DAC t_on input.
REQ-013 Port level, output, N: current envelope level.
REQ-014 Port busy, output, 1: high whenever the state is not IDLE.

Function
REQ-015 The block SHALL implement the states IDLE, ATTACK, DECAY, SUSTAIN and RELEASE.
REQ-016 A note_on pulse in any state SHALL move the state to ATTACK on the next clk, without changing level (retrigger without a click).
REQ-017 A note_off pulse in ATTACK, DECAY or SUSTAIN SHALL move the state to RELEASE on the next clk; note_off in IDLE or RELEASE is ignored.
REQ-018 If note_on and note_off are asserted in the same cycle, note_on SHALL win.
REQ-019 Level SHALL change only on a cycle with tick high in which neither note_on nor note_off is asserted; a note pulse takes priority and that tick is consumed with no step.
REQ-020 In ATTACK, each tick SHALL set level = min(level+ATTACK_STEP, 2^N-1); when the result is 2^N-1, the state becomes DECAY on the same edge.
REQ-021 In DECAY, each tick SHALL set level = max(level-DECAY_STEP, SUSTAIN_LVL); when the result equals SUSTAIN_LVL, the state becomes SUSTAIN.
REQ-022 In SUSTAIN, level SHALL hold at SUSTAIN_LVL.
REQ-023 In RELEASE, each tick SHALL set level = max(level-RELEASE_STEP, 0); when the result is 0, the state becomes IDLE.
REQ-024 In IDLE, level SHALL be 0.
REQ-025 Level arithmetic SHALL use N+1-bit intermediates so it cannot overflow or underflow (no wrap-around).
REQ-026 Every clk, sample_out SHALL be registered as bits [2N-1:N] of the 2N-bit product sample_in*level (latency 1 clk).
REQ-027 busy SHALL be registered together with the state and be consistent with it every cycle.

Reset
REQ-028 While reset is low, the state SHALL be IDLE, and level, sample_out and busy SHALL all be 0, asynchronously.
REQ-029 Reset asserted mid-tone SHALL abandon the tone immediately; after release, the block waits in IDLE for note_on.

Structure
REQ-030 A shared package envelope_pkg SHALL hold the state enumeration and the default step and sustain constants.
REQ-031 No sub-module is required; the state machine, level arithmetic and scaler SHALL reside in envelope_adsr.

Verification
REQ-032 Attack: from IDLE, note_on, then ticks -> level 16, 32, ...; the 16th tick gives 255 and state DECAY.
REQ-033 Decay/sustain: continue ticking -> 32 ticks later level = 128, state SUSTAIN; further ticks keep 128.
REQ-034 Release: note_off in SUSTAIN, then 64 ticks -> level 0, state IDLE, busy 0.
REQ-035 Scaling: sample_in = 200 -> sample_out = 199 with level 255, 100 with level 128, 0 in IDLE, each one clk after the level value.
REQ-036 Collisions: note_on, note_off and tick in the same cycle -> state ATTACK, level unchanged; note_on during RELEASE at level 60 -> ATTACK continues from 60.
REQ-037 Reset: assert reset low mid-ATTACK, not aligned to clk -> outputs 0 immediately; after release, state is IDLE.
